selfcheck_sequencer: RTL

- Hardware self-check controller for lab datapath units (ALU, shifter, register file, and similar).
- Walks a vector memory of {stimulus, expected result, expected bit count}, drives one DUT transaction per vector over a req/ack handshake, and compares the DUT's result and bit count against the expected values.
- Keeps pass, fail and step tallies so synthesized boards and benches report results without simulator-only code.

---
 rtl/selfcheck_pkg.sv | 17 +
 rtl/selfcheck_compare.sv | 22 ++
 rtl/selfcheck_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/selfcheck_pkg.sv
// selfcheck_pkg: shared widths, FSM states and vector record for the self-check sequencer
`ifndef WORD
`define WORD 64
`endif
package selfcheck_pkg;
  localparam int WORD_W = `WORD;
  localparam int DEF_BITS_W = 7;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_TIMEOUT = 1024;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, WAIT_ACK, CHECK, DONE} state_t;
  typedef struct packed {
    logic [WORD_W-1:0] stim;
    logic [WORD_W-1:0] exp;
    logic [DEF_BITS_W-1:0] exp_bits;
  } vec_t;
endpackage

// File: rtl/selfcheck_compare.sv
// selfcheck_compare: scores the DUT response against the captured expectation on the ack cycle
module selfcheck_compare #(
  parameter int WIDTH = 64,
  parameter int BITS_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_i,
  input  logic              tmo_i,
  input  logic [WIDTH-1:0]  result_i,
  input  logic [WIDTH-1:0]  exp_i,
  input  logic [BITS_W-1:0] bits_i,
  input  logic [BITS_W-1:0] exp_bits_i,
  output logic              pass_o
);
  logic pass_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pass_q <= 1'b0;
    else if (cap_i) pass_q <= !tmo_i && result_i == exp_i && bits_i == exp_bits_i;
  end
  assign pass_o = pass_q;
endmodule

// File: rtl/selfcheck_sequencer.sv
// selfcheck_sequencer: walks a vector memory, drives each vector into a DUT over req/ack
// and tallies pass/fail/step results with saturating counters.
module selfcheck_sequencer
  import selfcheck_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int BITS_W = DEF_BITS_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_vectors,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              vec_rd,
  input  logic [WIDTH-1:0]  vec_stim,
  input  logic [WIDTH-1:0]  vec_exp,
  input  logic [BITS_W-1:0] vec_exp_bits,
  output logic              dut_req,
  output logic [WIDTH-1:0]  dut_operand,
  input  logic              dut_ack,
  input  logic [WIDTH-1:0]  dut_result,
  input  logic [BITS_W-1:0] dut_result_bits,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic [CNT_W-1:0]  step,
  output logic [ADDR_W-1:0] first_fail
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state_q;
  vec_t vec_q;
  logic [ADDR_W:0] num_q, idx_q;
  logic [TW-1:0] tmo_q;
  logic [CNT_W-1:0] pass_q, fail_q, step_q;
  logic [ADDR_W-1:0] first_fail_q;
  logic vec_rd_q, dut_req_q, busy_q, done_q;
  logic tmo, cap, pass, last;
  // an ack on the final allowed cycle still wins over the timeout
  assign tmo = !dut_ack && tmo_q == TW'(TIMEOUT - 1);
  assign cap = (state_q == ISSUE || state_q == WAIT_ACK) && (dut_ack || tmo);
  assign last = idx_q + 1'b1 == num_q;
  selfcheck_compare #(.WIDTH(WIDTH), .BITS_W(BITS_W)) u_cmp (
    .clk(clk), .rst_n(rst_n), .cap_i(cap), .tmo_i(tmo),
    .result_i(dut_result), .exp_i(vec_q.exp),
    .bits_i(dut_result_bits), .exp_bits_i(vec_q.exp_bits),
    .pass_o(pass)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q <= '0;
      num_q <= '0;
      idx_q <= '0;
      tmo_q <= '0;
      pass_q <= '0;
      fail_q <= '0;
      step_q <= '0;
      first_fail_q <= '0;
      vec_rd_q <= 1'b0;
      dut_req_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      vec_rd_q <= 1'b0;
      case (state_q)
        IDLE, DONE: if (start) begin
          num_q <= num_vectors;
          idx_q <= '0;
          pass_q <= '0;
          fail_q <= '0;
          step_q <= '0;
          first_fail_q <= '0;
          state_q <= num_vectors == '0 ? DONE : FETCH;
          vec_rd_q <= num_vectors != '0;
          busy_q <= num_vectors != '0;
          done_q <= num_vectors == '0;
        end
        FETCH: state_q <= LOAD;
        LOAD: begin
          vec_q <= '{stim: vec_stim, exp: vec_exp, exp_bits: vec_exp_bits};
          tmo_q <= '0;
          dut_req_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE, WAIT_ACK: begin
          tmo_q <= tmo_q + 1'b1;
          dut_req_q <= !cap;
          state_q <= cap ? CHECK : WAIT_ACK;
        end
        CHECK: begin
          pass_q <= pass_q + CNT_W'(pass && ~&pass_q);
          fail_q <= fail_q + CNT_W'(!pass && ~&fail_q);
          step_q <= step_q + CNT_W'(~&step_q);
          if (!pass && fail_q == '0) first_fail_q <= idx_q[ADDR_W-1:0];
          idx_q <= idx_q + 1'b1;
          state_q <= last ? DONE : FETCH;
          vec_rd_q <= !last;
          busy_q <= !last;
          done_q <= last;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign vec_addr = idx_q[ADDR_W-1:0];
  assign vec_rd = vec_rd_q;
  assign dut_req = dut_req_q;
  assign dut_operand = vec_q.stim;
  assign busy = busy_q;
  assign done = done_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign step = step_q;
  assign first_fail = first_fail_q;
endmodule
